// File: rtl/dtt_if.sv
// Handshake and data bundle for the digital-to-time encoder dtt.
// Master drives start/input_vectors; slave returns the spike lines and finish.
interface dtt_if #(
    parameter int TTD_WIDTH = 5,
    parameter int N_NEURONS = 4
);
    logic                           start;
    logic [N_NEURONS*TTD_WIDTH-1:0] input_vectors;
    logic [N_NEURONS-1:0]           spikes;
    logic                           finish;

    modport master (
        output start,
        output input_vectors,
        input  spikes,
        input  finish
    );

    modport slave (
        input  start,
        input  input_vectors,
        output spikes,
        output finish
    );
endinterface

// File: rtl/dtt.sv
// Digital-to-time encoder: each nonzero code fires one spike at that cycle offset of the window.
// Optional macro DTT_EARLY_FINISH_EN ends the window once every pending channel has fired.
module dtt #(
    parameter int TTD_WIDTH = 5,
    parameter int N_NEURONS = 4
) (
    input logic CLK,
    input logic nRES,
    dtt_if.slave bus
);

    localparam logic [TTD_WIDTH-1:0] CNT_MAX = {TTD_WIDTH{1'b1}};

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                              state_q, state_d;
    logic [TTD_WIDTH-1:0]                cnt_q, cnt_d;
    logic [N_NEURONS-1:0][TTD_WIDTH-1:0] codes_q, codes_d;
    logic [N_NEURONS-1:0]                fired_q, fired_d;
    logic                                finish_q, finish_d;

    logic [N_NEURONS-1:0]                spikes_w;
    logic [N_NEURONS-1:0]                pending_w;
    logic                                window_done_w;

    // Spikes come only from registered state, so there is no input-to-output path.
    always_comb begin
        spikes_w  = '0;
        pending_w = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            pending_w[i] = (codes_q[i] != '0);
            spikes_w[i]  = (state_q == RUN) && (cnt_q == codes_q[i]) &&
                           pending_w[i] && !fired_q[i];
        end
    end

`ifdef DTT_EARLY_FINISH_EN
    assign window_done_w = ((fired_q | spikes_w) == pending_w) || (cnt_q == CNT_MAX);
`else
    assign window_done_w = (cnt_q == CNT_MAX);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        codes_d  = codes_q;
        fired_d  = fired_q;
        finish_d = finish_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    for (int i = 0; i < N_NEURONS; i++) begin
                        codes_d[i] = bus.input_vectors[i*TTD_WIDTH +: TTD_WIDTH];
                    end
                    fired_d  = '0;
                    finish_d = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                fired_d = fired_q | spikes_w;
                if (window_done_w) begin
                    cnt_d    = '0;
                    finish_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + TTD_WIDTH'(1);
                end
            end
            default: begin
                cnt_d    = '0;
                finish_d = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRES) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            codes_q  <= '0;
            fired_q  <= '0;
            finish_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            codes_q  <= codes_d;
            fired_q  <= fired_d;
            finish_q <= finish_d;
        end
    end

    assign bus.spikes = spikes_w;
    assign bus.finish = finish_q;

endmodule

// File: tb/tb_dtt.sv
// Directed bench for dtt: a per-cycle scoreboard of expected spikes/finish plus a
// behavioural spike-to-time-code converter for the loopback check.
module tb_dtt;

    localparam int W = 5;
    localparam int N = 4;

    logic CLK = 1'b0;
    logic nRES;

    dtt_if #(.TTD_WIDTH(W), .N_NEURONS(N)) bus ();

    dtt #(.TTD_WIDTH(W), .N_NEURONS(N)) dut (
        .CLK  (CLK),
        .nRES (nRES),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [N-1:0] spk;
        logic         fin;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   tests_run  = 0;
    int   fail_count = 0;

    // Behavioural converter: timestamps each spike relative to the common start edge.
    int         conv_t = 0;
    logic [W-1:0] conv_code [N];

    always @(posedge CLK) begin
        if (bus.start && bus.finish) begin
            conv_t <= 0;
            for (int i = 0; i < N; i++) conv_code[i] <= '0;
        end else begin
            conv_t <= conv_t + 1;
            for (int i = 0; i < N; i++) begin
                if (bus.spikes[i]) conv_code[i] <= W'(conv_t);
            end
        end
    end

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                            input logic [W-1:0] c2, input logic [W-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic int win_len(input logic [N*W-1:0] codes);
`ifdef DTT_EARLY_FINISH_EN
        int m = 0;
        for (int i = 0; i < N; i++) begin
            if (int'(codes[i*W +: W]) > m) m = int'(codes[i*W +: W]);
        end
        return m + 1;
`else
        return 1 << W;
`endif
    endfunction

    function automatic void push_cycle(input logic [N*W-1:0] codes, input int t, input int len);
        exp_t e;
        e.cyc = t;
        e.spk = '0;
        e.fin = (t >= len);
        if (t < len) begin
            for (int i = 0; i < N; i++) begin
                e.spk[i] = (codes[i*W +: W] != '0) && (int'(codes[i*W +: W]) == t);
            end
        end
        sb.push_back(e);
    endfunction

    task automatic checkOutput(input string tag);
        exp_t e;
        tests_run++;
        if (sb.size() == 0) begin
            fail_count++;
            $error("[TB] FAIL %s scoreboard empty: observed spikes=%b finish=%b, required an entry",
                   tag, bus.spikes, bus.finish);
            return;
        end
        e = sb.pop_front();
        assert (bus.spikes === e.spk) else begin
            fail_count++;
            $error("[TB] FAIL %s cycle %0d spikes: observed %b expected %b", tag, e.cyc, bus.spikes, e.spk);
        end
        tests_run++;
        assert (bus.finish === e.fin) else begin
            fail_count++;
            $error("[TB] FAIL %s cycle %0d finish: observed %b expected %b", tag, e.cyc, bus.finish, e.fin);
        end
    endtask

    // Called during an idle cycle; runs one whole window and ends in the following idle cycle.
    task automatic applyStimulus(input string tag, input logic [N*W-1:0] codes, input bit hold);
        int len;
        len = win_len(codes);
        bus.input_vectors = codes;
        bus.start = 1'b1;
        for (int t = 0; t <= len; t++) push_cycle(codes, t, len);
        for (int t = 0; t <= len; t++) begin
            @(posedge CLK);
            #1;
            checkOutput(tag);
            if (!hold) bus.start = 1'b0;
            bus.input_vectors = (t < len - 1) ? (N*W)'($urandom) : codes;
        end
    endtask

    task automatic idleCycles(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            sb.push_back('{spk: '0, fin: 1'b1, cyc: k});
            @(posedge CLK);
            #1;
            checkOutput(tag);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N*W-1:0] c;
        logic [W-1:0]   loop_exp [N];
        int             len;

        nRES = 1'b0;
        bus.start = 1'b0;
        bus.input_vectors = '0;
        repeat (2) @(posedge CLK);
        #1;
        nRES = 1'b1;

        idleCycles("reset_idle", 5);

        // Abort a window at cycle 4: channels 1 and 3 must never fire.
        c = pack(5'd3, 5'd7, 5'd1, 5'd12);
        len = win_len(c);
        bus.input_vectors = c;
        bus.start = 1'b1;
        for (int t = 0; t <= 4; t++) begin
            push_cycle(c, t, len);
            @(posedge CLK);
            #1;
            checkOutput("mid_reset_run");
            bus.start = 1'b0;
            if (t == 4) nRES = 1'b0;
        end
        @(posedge CLK);
        #1;
        nRES = 1'b1;
        sb.push_back('{spk: '0, fin: 1'b1, cyc: 0});
        checkOutput("mid_reset_abort");
        idleCycles("after_abort", 12);

        applyStimulus("codes_3_7_1_12", pack(5'd3, 5'd7, 5'd1, 5'd12), 1'b0);
        idleCycles("gap1", 2);

        applyStimulus("codes_0_31_5_5", pack(5'd0, 5'd31, 5'd5, 5'd5), 1'b0);
        idleCycles("gap2", 1);

        c = pack(5'd2, 5'd2, 5'd2, 5'd2);
        applyStimulus("held_start_w1", c, 1'b1);
        applyStimulus("held_start_w2", c, 1'b1);
        applyStimulus("held_start_w3", c, 1'b0);
        idleCycles("gap3", 2);

        applyStimulus("all_zero", pack(5'd0, 5'd0, 5'd0, 5'd0), 1'b0);
        idleCycles("gap4", 2);

        applyStimulus("loopback", pack(5'd9, 5'd4, 5'd17, 5'd30), 1'b0);
        loop_exp[0] = 5'd9;
        loop_exp[1] = 5'd4;
        loop_exp[2] = 5'd17;
        loop_exp[3] = 5'd30;
        for (int i = 0; i < N; i++) begin
            tests_run++;
            assert (conv_code[i] === loop_exp[i]) else begin
                fail_count++;
                $error("[TB] FAIL loopback_ch%0d: observed %0d expected %0d", i, conv_code[i], loop_exp[i]);
            end
        end
        idleCycles("final_idle", 3);

        if (sb.size() != 0) begin
            fail_count++;
            $display("[TB] FAIL scoreboard_drain: observed %0d leftover entries, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/dtt.md
Name: dtt

Overview:
- Digital-to-time encoder: converts a vector of per-neuron time codes into a single spike burst on N spike lines.
- Each spike occurs at the cycle offset given by its code.
- Inverse of the spike-to-time-code converter on the SNN datapath.
- Drives input spikes into the next layer, or loops back for latency-code round-trip tests. A code of 0 means "no spike".

Parameters:
- TTD_WIDTH, 5: width of each time code and of the internal cycle counter.
- N_NEURONS, 4: number of channels (time codes in, spike lines out).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- nRES  input  1  reset, synchronous, active-low.
- start  input  1  request a new encoding window; accepted only while finish=1.
- input_vectors  input  N_NEURONS*TTD_WIDTH  time codes, flattened; channel i at bits [i*TTD_WIDTH +: TTD_WIDTH]; sampled only on the accepting edge.
- spikes  output  N_NEURONS  one-cycle spike pulses.
- finish  output  1  1 = idle/window complete, 0 = window in progress.

Behaviour:
- Reset: nRES=0 at a rising edge sets finish=1, cnt=0, latched codes=0, fired mask=0, spikes=0. Applies mid-window too: the window is aborted and no further spikes are issued.
- States:
  - IDLE (finish=1): cnt held at 0, spikes=0.
  - RUN (finish=0).
- IDLE->RUN: edge with start=1 && finish=1.
  - Latch all codes.
  - Clear the fired mask.
  - finish<=0, cnt<=0.
- start while finish=0 is ignored. Latched codes do not change and input_vectors is not sampled.
- Cycle numbering: cycle t = t-th cycle after the accepting edge. cnt=t during cycle t; cnt increments by 1 each edge in RUN.
- Spike rule: spikes[i]=1 during cycle t iff all of the following hold:
  - state is RUN;
  - cnt == code[i];
  - code[i] != 0;
  - fired[i]=0.
  The spike is decoded from registered state only (cnt, codes, fired, finish), with no combinational path from inputs. On that edge fired[i]<=1.
- Spikes are therefore exactly one cycle wide, at most one per channel per window. A code equal to 0 never spikes.
- Several channels with equal codes spike in the same cycle.
- Window end: the edge at which cnt == all-ones (2^TTD_WIDTH-1) sets finish<=1 and cnt<=0.
  - cnt never wraps within a window.
  - Code all-ones spikes in the final cycle.
- RUN->IDLE transition: spikes=0 in the first IDLE cycle.
- start=1 in the first IDLE cycle is accepted; back-to-back windows are separated by exactly one finish=1 cycle.
- Round-trip property: if this block and the spike-to-time-code converter receive the same start edge and spikes feeds its spike inputs, the converter records each nonzero code unchanged.

Optional Feature:
- Macro: DTT_EARLY_FINISH_EN.
- Defined: window ends early.
  - Pending mask = channels with nonzero latched code.
  - On the edge where (fired | spikes) == pending mask, finish<=1 and cnt<=0.
  - All-zero codes: finish returns to 1 after cycle 0, i.e. a one-cycle window.
- Not defined: window always runs the full 2^TTD_WIDTH cycles (cycles 0..31 for width 5) regardless of spikes.

Test Plan:
- Reset, then idle 5 cycles with start=0 -> finish=1, spikes=0 throughout; assert nRES=0 mid-window at cycle 4 -> finish=1 next cycle, no spikes afterwards.
- Codes ch0..3 = {3,7,1,12}, start pulse -> spikes[2] in cycle 1, spikes[0] cycle 3, spikes[1] cycle 7, spikes[3] cycle 12, each exactly one cycle. finish=1 from cycle 13 with DTT_EARLY_FINISH_EN, from cycle 32 without.
- Codes {0,31,5,5} -> ch0 never spikes; ch2 and ch3 spike together in cycle 5; ch1 spikes in cycle 31; finish=1 at cycle 32 in both builds.
- start held high continuously with codes {2,2,2,2} -> with early-finish: spikes=4'b1111 in cycle 2, finish=1 for one cycle, new window accepted, pattern repeats every 4 cycles. Changing input_vectors mid-window has no effect.
- All codes 0 -> no spikes; finish=1 in cycle 1 with DTT_EARLY_FINISH_EN, cycle 32 without.
- Loopback into the spike-to-time-code converter with common start, codes {9,4,17,30} -> converter output vectors read back {9,4,17,30}.
